range_pwm_driver: RTL and testbench

Downstream consumer of the two 8-bit range values produced by the HPS-facing Avalon-MM write register. Converts range1/range2 into two glitch-free PWM outputs for the actuator drivers. Duty changes take effect only at PWM period boundaries and are slew-limited. A watchdog returns both channels to a safe duty when the range inputs go stale.

---
 rtl/range_pwm_driver.sv | 131 +++++++++++++
 tb/tb_range_pwm_driver.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_pwm_driver.sv
// Two-channel PWM driver fed by upstream range registers. Duty changes are applied
// only at period boundaries and are slew-limited. A watchdog falls back to SAFE_DUTY.
module range_pwm_driver #(
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned RAMP_STEP    = 4,
    parameter int unsigned IDLE_PERIODS = 1000,
    parameter logic [7:0]  SAFE_DUTY    = 8'd128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] range1,
    input  logic [7:0] range2,
    output logic       pwm1,
    output logic       pwm2,
    output logic [7:0] duty1,
    output logic [7:0] duty2,
    output logic       period_start,
    output logic       settled,
    output logic       idle_fallback
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PRE_MAX    = PW'(PRESCALE - 1);
    localparam logic [15:0]       IDLE_LIMIT = 16'(IDLE_PERIODS);
    localparam logic signed [8:0] STEP       = 9'(RAMP_STEP);

    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic [7:0]    duty1_q, duty1_d, duty2_q, duty2_d;
    logic          pwm1_q, pwm1_d, pwm2_q, pwm2_d;
    logic          period_start_q, period_start_d;
    logic          settled_q, settled_d;
    logic          idle_fallback_q, idle_fallback_d;
    logic [15:0]   idle_cnt_q, idle_cnt_d;
    logic [7:0]    last_r1_q, last_r1_d, last_r2_q, last_r2_d;

    logic          tick, boundary, change;
    logic [7:0]    target1, target2;

    // The step is only taken when the gap exceeds it, so the result can never overshoot or wrap.
    function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] tgt);
        logic signed [8:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP) begin
            return cur + 8'(RAMP_STEP);
        end else if (diff < -STEP) begin
            return cur - 8'(RAMP_STEP);
        end
        return tgt;
    endfunction

    always_comb begin
        tick     = (pre_q == PRE_MAX);
        boundary = tick && (pcnt_q == 8'hFF);
        change   = (range1 != last_r1_q) || (range2 != last_r2_q);
        target1  = idle_fallback_q ? SAFE_DUTY : range1;
        target2  = idle_fallback_q ? SAFE_DUTY : range2;

        pre_d  = tick ? '0 : pre_q + 1'b1;
        pcnt_d = tick ? pcnt_q + 8'd1 : pcnt_q;

        duty1_d   = duty1_q;
        duty2_d   = duty2_q;
        settled_d = settled_q;
        if (boundary) begin
            duty1_d   = ramp(duty1_q, target1);
            duty2_d   = ramp(duty2_q, target2);
            settled_d = (duty1_d == target1) && (duty2_d == target2);
        end
        period_start_d = boundary;

        pwm1_d = enable && (pcnt_q < duty1_q);
        pwm2_d = enable && (pcnt_q < duty2_q);

        // A fresh write always wins over a boundary increment in the same cycle.
        idle_cnt_d      = idle_cnt_q;
        idle_fallback_d = idle_fallback_q;
        if (change) begin
            idle_cnt_d      = '0;
            idle_fallback_d = 1'b0;
        end else if (boundary && (IDLE_LIMIT != 16'd0) && (idle_cnt_q < IDLE_LIMIT)) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
            if (idle_cnt_d == IDLE_LIMIT) begin
                idle_fallback_d = 1'b1;
            end
        end

        last_r1_d = range1;
        last_r2_d = range2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q           <= '0;
            pcnt_q          <= '0;
            duty1_q         <= SAFE_DUTY;
            duty2_q         <= SAFE_DUTY;
            pwm1_q          <= 1'b0;
            pwm2_q          <= 1'b0;
            period_start_q  <= 1'b0;
            settled_q       <= 1'b0;
            idle_fallback_q <= 1'b0;
            idle_cnt_q      <= '0;
            last_r1_q       <= SAFE_DUTY;
            last_r2_q       <= SAFE_DUTY;
        end else begin
            pre_q           <= pre_d;
            pcnt_q          <= pcnt_d;
            duty1_q         <= duty1_d;
            duty2_q         <= duty2_d;
            pwm1_q          <= pwm1_d;
            pwm2_q          <= pwm2_d;
            period_start_q  <= period_start_d;
            settled_q       <= settled_d;
            idle_fallback_q <= idle_fallback_d;
            idle_cnt_q      <= idle_cnt_d;
            last_r1_q       <= last_r1_d;
            last_r2_q       <= last_r2_d;
        end
    end

    assign pwm1          = pwm1_q;
    assign pwm2          = pwm2_q;
    assign duty1         = duty1_q;
    assign duty2         = duty2_q;
    assign period_start  = period_start_q;
    assign settled       = settled_q;
    assign idle_fallback = idle_fallback_q;

endmodule

// File: tb/tb_range_pwm_driver.sv
// Bench for range_pwm_driver: three instances with different parameters share one
// stimulus stream and are compared every cycle against an arithmetic reference model.
module tb_range_pwm_driver;

    localparam int PS0 = 1, RS0 = 4, IP0 = 0;
    localparam int PS1 = 1, RS1 = 4, IP1 = 3;
    localparam int PS2 = 3, RS2 = 7, IP2 = 2;
    localparam int SAFE = 128;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] range1;
    logic [7:0] range2;

    logic       o_pwm1 [3];
    logic       o_pwm2 [3];
    logic [7:0] o_duty1 [3];
    logic [7:0] o_duty2 [3];
    logic       o_ps [3];
    logic       o_set [3];
    logic       o_fb [3];

    int n_cmp = 0;
    int n_bad = 0;

    int ps [3] = '{PS0, PS1, PS2};
    int rs [3] = '{RS0, RS1, RS2};
    int ip [3] = '{IP0, IP1, IP2};

    range_pwm_driver #(.PRESCALE(PS0), .RAMP_STEP(RS0), .IDLE_PERIODS(IP0), .SAFE_DUTY(8'd128)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .range1(range1), .range2(range2),
        .pwm1(o_pwm1[0]), .pwm2(o_pwm2[0]), .duty1(o_duty1[0]), .duty2(o_duty2[0]),
        .period_start(o_ps[0]), .settled(o_set[0]), .idle_fallback(o_fb[0]));

    range_pwm_driver #(.PRESCALE(PS1), .RAMP_STEP(RS1), .IDLE_PERIODS(IP1), .SAFE_DUTY(8'd128)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .range1(range1), .range2(range2),
        .pwm1(o_pwm1[1]), .pwm2(o_pwm2[1]), .duty1(o_duty1[1]), .duty2(o_duty2[1]),
        .period_start(o_ps[1]), .settled(o_set[1]), .idle_fallback(o_fb[1]));

    range_pwm_driver #(.PRESCALE(PS2), .RAMP_STEP(RS2), .IDLE_PERIODS(IP2), .SAFE_DUTY(8'd128)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .range1(range1), .range2(range2),
        .pwm1(o_pwm1[2]), .pwm2(o_pwm2[2]), .duty1(o_duty1[2]), .duty2(o_duty2[2]),
        .period_start(o_ps[2]), .settled(o_set[2]), .idle_fallback(o_fb[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: time is a plain cycle count since reset, from which the tick
    // phase and period position are derived by division; duties move by saturating steps.
    int m_cyc [3];
    int m_duty [3][2];
    int m_last [3][2];
    int m_idle [3];
    bit m_pwm [3][2];
    bit m_ps [3];
    bit m_set [3];
    bit m_fb [3];
    bit mt_bnd;
    bit mt_chg;
    int mt_pos;
    int mt_tgt [2];
    int mt_rng [2];

    function automatic int step_toward(input int cur, input int tgt, input int r);
        if (tgt > cur + r) return cur + r;
        if (tgt < cur - r) return cur - r;
        return tgt;
    endfunction

    always @(posedge clk) begin
        mt_rng[0] = int'(range1);
        mt_rng[1] = int'(range2);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_cyc[k] = 0;
                m_idle[k] = 0;
                m_ps[k] = 1'b0;
                m_set[k] = 1'b0;
                m_fb[k] = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    m_duty[k][c] = SAFE;
                    m_last[k][c] = SAFE;
                    m_pwm[k][c] = 1'b0;
                end
            end else begin
                mt_pos = (m_cyc[k] / ps[k]) % 256;
                mt_bnd = (m_cyc[k] % (256 * ps[k])) == (256 * ps[k] - 1);
                mt_chg = (mt_rng[0] != m_last[k][0]) || (mt_rng[1] != m_last[k][1]);
                for (int c = 0; c < 2; c++) begin
                    m_pwm[k][c] = enable && (mt_pos < m_duty[k][c]);
                end
                if (mt_bnd) begin
                    for (int c = 0; c < 2; c++) begin
                        mt_tgt[c] = m_fb[k] ? SAFE : mt_rng[c];
                        m_duty[k][c] = step_toward(m_duty[k][c], mt_tgt[c], rs[k]);
                    end
                    m_set[k] = (m_duty[k][0] == mt_tgt[0]) && (m_duty[k][1] == mt_tgt[1]);
                end
                m_ps[k] = mt_bnd;
                if (mt_chg) begin
                    m_idle[k] = 0;
                    m_fb[k] = 1'b0;
                end else if (mt_bnd && ip[k] != 0 && m_idle[k] < ip[k]) begin
                    m_idle[k] = m_idle[k] + 1;
                    if (m_idle[k] == ip[k]) m_fb[k] = 1'b1;
                end
                m_cyc[k] = m_cyc[k] + 1;
                m_last[k][0] = mt_rng[0];
                m_last[k][1] = mt_rng[1];
            end
        end
    end

    typedef struct {
        logic [7:0] r1;
        logic [7:0] r2;
        int         periods;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       set;
        int         high;
    } vec_t;

    vec_t tbl [8];

    task automatic check_output(input string name, input int actual, input int required);
        n_cmp++;
        if (actual != required) begin
            n_bad++;
            $display("[TB] FAIL %s t=%0t actual=%0d required=%0d", name, $time, actual, required);
        end
    endtask

    // Advance one cycle and compare every output of every instance with the model.
    task automatic tick_cycle();
        logic [20:0] act;
        logic [20:0] req;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            act = {o_duty1[k], o_duty2[k], o_pwm1[k], o_pwm2[k], o_ps[k], o_set[k], o_fb[k]};
            req = {8'(m_duty[k][0]), 8'(m_duty[k][1]), m_pwm[k][0], m_pwm[k][1],
                   m_ps[k], m_set[k], m_fb[k]};
            n_cmp++;
            if (act !== req) begin
                n_bad++;
                $display("[TB] FAIL model_u%0d t=%0t actual=%h required=%h", k, $time, act, req);
            end
        end
    endtask

    task automatic wait_periods(input int n);
        int seen = 0;
        int budget = n * 256 + 8;
        while (seen < n && budget > 0) begin
            tick_cycle();
            budget--;
            if (o_ps[0]) seen++;
        end
        if (seen < n) begin
            n_bad++;
            $display("[TB] FAIL period_timeout actual=%0d required=%0d", seen, n);
        end
    endtask

    task automatic wait_pcnt(input int v);
        int budget = 600;
        while ((m_cyc[0] % 256) != v && budget > 0) begin
            tick_cycle();
            budget--;
        end
        if (budget == 0) begin
            n_bad++;
            $display("[TB] FAIL pcnt_timeout actual=%0d required=%0d", m_cyc[0] % 256, v);
        end
    endtask

    task automatic measure_period(input int exp_high);
        int high = 0;
        int pulses = 0;
        for (int i = 0; i < 256; i++) begin
            tick_cycle();
            high += int'(o_pwm1[0]);
            pulses += int'(o_ps[0]);
        end
        check_output("pwm1_high_count", high, exp_high);
        check_output("period_start_per_256", pulses, 1);
    endtask

    task automatic apply_stimulus(input logic [7:0] r1, input logic [7:0] r2, input logic en);
        range1 = r1;
        range2 = r2;
        enable = en;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick_cycle();
        tick_cycle();
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'h80, 8'h80, 1,  8'h80, 8'h80, 1'b1, 128};
        tbl[1] = '{8'h90, 8'h80, 3,  8'h8C, 8'h80, 1'b0, -1};
        tbl[2] = '{8'h90, 8'h80, 1,  8'h90, 8'h80, 1'b1, 144};
        tbl[3] = '{8'h02, 8'h80, 36, 8'h02, 8'h80, 1'b1, 2};
        tbl[4] = '{8'h00, 8'h80, 1,  8'h00, 8'h80, 1'b1, 0};
        tbl[5] = '{8'hFF, 8'h80, 63, 8'hFC, 8'h80, 1'b0, -1};
        tbl[6] = '{8'hFF, 8'h80, 1,  8'hFF, 8'h80, 1'b1, 255};
        tbl[7] = '{8'h10, 8'h7E, 1,  8'hFB, 8'h7E, 1'b0, -1};

        reset = 1'b1;
        apply_stimulus(8'h80, 8'h80, 1'b1);
        tick_cycle();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            check_output("reset_duty1", int'(o_duty1[k]), 128);
            check_output("reset_pwm1", int'(o_pwm1[k]), 0);
            check_output("reset_settled", int'(o_set[k]), 0);
            check_output("reset_fallback", int'(o_fb[k]), 0);
        end

        // Enable gating mid-period.
        wait_pcnt(50);
        enable = 1'b0;
        tick_cycle();
        check_output("pwm1_after_disable", int'(o_pwm1[0]), 0);
        wait_pcnt(60);
        check_output("pwm1_while_disabled", int'(o_pwm1[0]), 0);
        enable = 1'b1;
        tick_cycle();
        check_output("pwm1_after_reenable", int'(o_pwm1[0]), 1);
        check_output("duty1_during_disable", int'(o_duty1[0]), 128);

        // Ramp 0x80 -> 0x90 on the watchdog instance, kept alive by toggling range2.
        range1 = 8'h90;
        for (int i = 0; i < 4; i++) begin
            wait_periods(1);
            check_output("ramp_duty1", int'(o_duty1[1]), 8'h80 + 4 * (i + 1));
            check_output("ramp_settled", int'(o_set[1]), (i == 3) ? 1 : 0);
            range2 = range2 ^ 8'h01;
        end
        wait_periods(3);
        check_output("fallback_set_u1", int'(o_fb[1]), 1);
        check_output("fallback_duty_hold", int'(o_duty1[1]), 8'h90);
        wait_pcnt(100);
        reset = 1'b1;
        tick_cycle();
        check_output("midreset_duty1", int'(o_duty1[1]), 128);
        check_output("midreset_fallback", int'(o_fb[1]), 0);
        check_output("midreset_settled", int'(o_set[1]), 0);
        check_output("midreset_pwm1", int'(o_pwm1[1]), 0);
        reset = 1'b0;

        // Watchdog fallback from a settled 0xF0 and recovery on a new write.
        range1 = 8'hF0;
        for (int i = 0; i < 28; i++) begin
            wait_periods(1);
            range2 = range2 ^ 8'h01;
        end
        check_output("wd_duty1_settled", int'(o_duty1[1]), 8'hF0);
        wait_periods(3);
        check_output("wd_fallback_set", int'(o_fb[1]), 1);
        check_output("wd_duty1_at_set", int'(o_duty1[1]), 8'hF0);
        wait_periods(1);
        check_output("wd_ramp_down_1", int'(o_duty1[1]), 8'hEC);
        wait_periods(1);
        check_output("wd_ramp_down_2", int'(o_duty1[1]), 8'hE8);
        range1 = 8'hF1;
        tick_cycle();
        check_output("wd_fallback_clear", int'(o_fb[1]), 0);
        wait_periods(1);
        check_output("wd_ramp_up", int'(o_duty1[1]), 8'hEC);

        // Table-driven sequence on the instance without a watchdog.
        apply_stimulus(8'h80, 8'h80, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(tbl[i].r1, tbl[i].r2, 1'b1);
            wait_periods(tbl[i].periods);
            check_output($sformatf("tbl%0d_duty1", i), int'(o_duty1[0]), int'(tbl[i].d1));
            check_output($sformatf("tbl%0d_duty2", i), int'(o_duty2[0]), int'(tbl[i].d2));
            check_output($sformatf("tbl%0d_settled", i), int'(o_set[0]), int'(tbl[i].set));
            if (tbl[i].high >= 0) measure_period(tbl[i].high);
        end

        // Random phase checked only against the model.
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 255)) tick_cycle();
            apply_stimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                           $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                tick_cycle();
                reset = 1'b0;
            end
            wait_periods(int'($urandom_range(0, 4)));
        end
        tick_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
